// File: rtl/stim_pkg.sv
// stim_pkg -- shared definitions for the biphasic stimulation pulse generator.
//   state_e      : burst sequencer states
//   DEF_*        : default timing constants and amplitude width
//   TMR_W        : phase timer width
//   dur_load()   : timer load value for a duration given in cycles
package stim_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CATH    = 3'd1,
      ST_IPG     = 3'd2,
      ST_ANOD    = 3'd3,
      ST_GAP     = 3'd4,
      ST_REFRACT = 3'd5
   } state_e;

   localparam int DEF_AMP_WIDTH      = 16;
   localparam int DEF_PHASE_CYCLES   = 10;
   localparam int DEF_IPG_CYCLES     = 2;
   localparam int DEF_GAP_CYCLES     = 20;
   localparam int DEF_PULSES         = 4;
   localparam int DEF_REFRACT_CYCLES = 1000;

   localparam int TMR_W = 16;

   // The timer counts duration-1 down to 0, so a state lasts exactly
   // 'cycles' clocks including its entry cycle.
   function automatic logic [TMR_W-1:0] dur_load(input int cycles);
      return TMR_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/stim_timer.sv
// stim_timer -- loadable 16-bit down-counter with zero flag.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset (counter clears to 0)
//   load     : load load_val on the next edge (takes priority over counting)
//   load_val : value to load
//   zero     : counter currently at 0; the counter holds at 0 (no wrap)
module stim_timer
   import stim_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             zero
);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/stim_pulse_gen.sv
// stim_pulse_gen -- biphasic stimulation burst generator.
// A rising edge on 'stimulation' in IDLE (with en high) launches a burst of
// PULSES biphasic pulses (cathodic, interphase gap, anodic, inter-pulse gap),
// followed by a refractory lockout, then a one-cycle 'done'.
//   clk, rst    : clock / asynchronous active-low reset
//   en          : enable; low aborts to IDLE on the next edge
//   stimulation : trigger level, rising edge starts a burst
//   amp         : amplitude code, latched at trigger
//   phase_neg   : cathodic drive      phase_pos : anodic drive
//   amp_out     : latched amplitude while a phase is active, else 0
//   busy        : burst or refractory in progress
//   done        : one-cycle pulse when refractory ends
//   pulse_cnt   : completed biphasic pulses in the current burst
module stim_pulse_gen
   import stim_pkg::*;
#(
   parameter int AMP_WIDTH      = DEF_AMP_WIDTH,
   parameter int PHASE_CYCLES   = DEF_PHASE_CYCLES,
   parameter int IPG_CYCLES     = DEF_IPG_CYCLES,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int PULSES         = DEF_PULSES,
   parameter int REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 stimulation,
   input  logic [AMP_WIDTH-1:0] amp,
   output logic                 phase_neg,
   output logic                 phase_pos,
   output logic [AMP_WIDTH-1:0] amp_out,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           pulse_cnt
);

   state_e               state_q, state_d;
   logic                 stim_prev_q;
   logic [AMP_WIDTH-1:0] amp_lat_q, amp_lat_d;
   logic [7:0]           pulse_cnt_q, pulse_cnt_d;
   logic                 phase_neg_q, phase_neg_d;
   logic                 phase_pos_q, phase_pos_d;
   logic [AMP_WIDTH-1:0] amp_out_q, amp_out_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_zero;
   logic             trig;
   logic [7:0]       pulse_inc;

   stim_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // Only a fresh rise while idle starts a burst; anything else is dropped.
   assign trig      = stimulation & ~stim_prev_q & (state_q == ST_IDLE);
   assign pulse_inc = pulse_cnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      amp_lat_d   = amp_lat_q;
      pulse_cnt_d = pulse_cnt_q;
      done_d      = 1'b0;
      tmr_load    = 1'b0;
      tmr_val     = '0;

      if (!en) begin
         // Abort: timer reloaded with 0 so no stale count survives.
         state_d     = ST_IDLE;
         pulse_cnt_d = '0;
         tmr_load    = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: if (trig) begin
               state_d     = ST_CATH;
               amp_lat_d   = amp;
               pulse_cnt_d = '0;
               tmr_load    = 1'b1;
               tmr_val     = dur_load(PHASE_CYCLES);
            end
            ST_CATH: if (tmr_zero) begin
               state_d  = ST_IPG;
               tmr_load = 1'b1;
               tmr_val  = dur_load(IPG_CYCLES);
            end
            ST_IPG: if (tmr_zero) begin
               state_d  = ST_ANOD;
               tmr_load = 1'b1;
               tmr_val  = dur_load(PHASE_CYCLES);
            end
            ST_ANOD: if (tmr_zero) begin
               pulse_cnt_d = pulse_inc;
               tmr_load    = 1'b1;
               if (pulse_inc == 8'(PULSES)) begin
                  state_d = ST_REFRACT;
                  tmr_val = dur_load(REFRACT_CYCLES);
               end else begin
                  state_d = ST_GAP;
                  tmr_val = dur_load(GAP_CYCLES);
               end
            end
            ST_GAP: if (tmr_zero) begin
               state_d  = ST_CATH;
               tmr_load = 1'b1;
               tmr_val  = dur_load(PHASE_CYCLES);
            end
            ST_REFRACT: if (tmr_zero) begin
               state_d     = ST_IDLE;
               pulse_cnt_d = '0;
               done_d      = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Outputs are decoded from the next state and registered, so the
      // first cathodic cycle follows the trigger edge directly. A single
      // state value makes both phases high at once impossible.
      phase_neg_d = (state_d == ST_CATH);
      phase_pos_d = (state_d == ST_ANOD);
      amp_out_d   = (phase_neg_d | phase_pos_d) ? amp_lat_d : '0;
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         stim_prev_q <= 1'b1;  // level already high at release is not an edge
         amp_lat_q   <= '0;
         pulse_cnt_q <= '0;
         phase_neg_q <= 1'b0;
         phase_pos_q <= 1'b0;
         amp_out_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         stim_prev_q <= stimulation;
         amp_lat_q   <= amp_lat_d;
         pulse_cnt_q <= pulse_cnt_d;
         phase_neg_q <= phase_neg_d;
         phase_pos_q <= phase_pos_d;
         amp_out_q   <= amp_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign phase_neg = phase_neg_q;
   assign phase_pos = phase_pos_q;
   assign amp_out   = amp_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pulse_cnt = pulse_cnt_q;

endmodule
